// File: rtl/simple_pipe_fetch.sv
// Instruction fetch/issue buffer: DEPTH-entry FIFO feeding a registered issue slot that emits NOP bubbles when idle.
// Optional issue/bubble statistics counters are built when SIMPLE_PIPE_FETCH_CNT_EN is defined.
module simple_pipe_fetch #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_inst,
    output logic                     in_ready,
    input  logic                     issue_en,
    input  logic                     flush,
    output logic [7:0]               inst,
    output logic                     inst_valid,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef SIMPLE_PIPE_FETCH_CNT_EN
    ,
    output logic [CNT_W-1:0]         issued_cnt,
    output logic [CNT_W-1:0]         bubble_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    inst_q, inst_d;
    logic          inst_valid_q, inst_valid_d;
    logic [7:0]    mem_q [DEPTH];
    logic          push, pop;

    // Handshake: a word transfers on a rising edge where in_valid && in_ready; in_ready
    // never depends on in_valid, and is held low during reset, on flush, and when full.
    assign in_ready = rst && !flush && (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = !flush && issue_en && (count_q != '0);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        inst_d       = 8'h00;
        inst_valid_d = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d     = rd_ptr_q + PW'(1);
                inst_d       = mem_q[rd_ptr_q];
                inst_valid_d = 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            inst_q       <= 8'h00;
            inst_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Storage needs no reset: entries are only read when counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_inst;
        end
    end

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign fifo_count = count_q;

`ifdef SIMPLE_PIPE_FETCH_CNT_EN
    logic [CNT_W-1:0] issued_cnt_q, bubble_cnt_q;

    // Flush is not a reset for the statistics; it only shows up as a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued_cnt_q <= '0;
            bubble_cnt_q <= '0;
        end else begin
            issued_cnt_q <= issued_cnt_q + CNT_W'(inst_valid_d);
            bubble_cnt_q <= bubble_cnt_q + CNT_W'(!inst_valid_d);
        end
    end

    assign issued_cnt = issued_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
